// File: rtl/alu_dadd_serial_pkg.sv
// Shared types and constants for the XM23 digit-serial BCD add/subtract unit.
package xm23_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dadd_state_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ADJ  = 4'd6;

  // Modulo-16 nines complement; applying it twice returns the original digit,
  // which lets the top recover B from B' without storing both.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/alu_dadd_serial_if.sv
// Request/result valid-ready bundle for alu_dadd_serial.
interface alu_dadd_serial_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_invalid;

  modport master (
    output in_valid, in_sub, in_a, in_b, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_invalid
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_invalid
  );

endinterface

// File: rtl/alu_dadd_serial_bcd_digit_add.sv
// One BCD digit of addition: 5-bit binary sum, decimal-adjusted when above nine.
module bcd_digit_add
  import xm23_bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) begin
      sum  = s[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      sum  = s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/alu_dadd_serial.sv
// Digit-serial BCD add/subtract: one digit per clock, LSD first, through a single digit adder.
module alu_dadd_serial
  import xm23_bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_dadd_serial_if.slave bus
);

  localparam int            W    = 4 * DIGITS;
  localparam int            CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  dadd_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          carry_q, carry_d, sub_q, sub_d, inv_q, inv_d, zero_q, zero_d;
  logic [W-1:0]  out_result_q, out_result_d;
  logic          out_carry_q, out_carry_d, out_zero_q, out_zero_d, out_inv_q, out_inv_d;

  logic [W-1:0]  b_comp;
  bcd_digit_t    b_orig, dig_sum;
  logic          dig_cout;

  always_comb begin
    b_comp = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b_comp[4*i +: 4] = nines_comp(bus.in_b[4*i +: 4]);
    end
  end

  // Invalid-digit checks must see B as presented, so undo the complement here.
  assign b_orig = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];

  bcd_digit_add u_digit (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    carry_d      = carry_q;
    sub_d        = sub_q;
    inv_d        = inv_q;
    zero_d       = zero_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_inv_d    = out_inv_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? b_comp : bus.in_b;
          carry_d = bus.in_carry;
          sub_d   = bus.in_sub;
          cnt_d   = '0;
          res_d   = '0;
          inv_d   = 1'b0;
          zero_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = (res_q >> 4) | (W'(dig_sum) << (W - 4));
        carry_d = dig_cout;
        inv_d   = inv_q | (a_q[3:0] > BCD_NINE) | (b_orig > BCD_NINE);
        zero_d  = zero_q & (dig_sum == 4'd0);
        cnt_d   = cnt_q + CW'(1);
        // Visible outputs only move on the final digit so they hold through DONE.
        if (cnt_q == LAST) begin
          state_d      = DONE;
          out_result_d = res_d;
          out_carry_d  = dig_cout;
          out_zero_d   = zero_d;
          out_inv_d    = inv_d;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      sub_q        <= 1'b0;
      inv_q        <= 1'b0;
      zero_q       <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_inv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      sub_q        <= sub_d;
      inv_q        <= inv_d;
      zero_q       <= zero_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_inv_q    <= out_inv_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_result  = out_result_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_invalid = out_inv_q;

endmodule

// File: tb/tb_alu_dadd_serial.sv
// Self-checking bench: directed vector table, handshake/reset sequences, and random ops vs a decimal model.
module tb_alu_dadd_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] got_res;
  logic        got_c, got_z, got_inv;
  int          got_lat;

  alu_dadd_serial_if #(.DIGITS(4)) if4 ();
  alu_dadd_serial_if #(.DIGITS(1)) if1 ();
  alu_dadd_serial_if #(.DIGITS(8)) if8 ();

  alu_dadd_serial #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  alu_dadd_serial #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_dadd_serial #(.DIGITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit          sub;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] res;
    bit          carry;
    bit          zero;
    bit          inv;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int digits_of(input int w);
    case (w)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic get_ready(input int w);
    case (w)
      0:       return if4.in_ready;
      1:       return if1.in_ready;
      default: return if8.in_ready;
    endcase
  endfunction

  function automatic logic get_valid(input int w);
    case (w)
      0:       return if4.out_valid;
      1:       return if1.out_valid;
      default: return if8.out_valid;
    endcase
  endfunction

  task automatic sample(input int w);
    case (w)
      0: begin
        got_res = 32'(if4.out_result); got_c = if4.out_carry;
        got_z = if4.out_zero; got_inv = if4.out_invalid;
      end
      1: begin
        got_res = 32'(if1.out_result); got_c = if1.out_carry;
        got_z = if1.out_zero; got_inv = if1.out_invalid;
      end
      default: begin
        got_res = if8.out_result; got_c = if8.out_carry;
        got_z = if8.out_zero; got_inv = if8.out_invalid;
      end
    endcase
  endtask

  task automatic drive(input int w, input bit v, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input bit c);
    case (w)
      0: begin
        if4.in_valid = v; if4.in_sub = s; if4.in_a = a[15:0]; if4.in_b = b[15:0]; if4.in_carry = c;
      end
      1: begin
        if1.in_valid = v; if1.in_sub = s; if1.in_a = a[3:0]; if1.in_b = b[3:0]; if1.in_carry = c;
      end
      default: begin
        if8.in_valid = v; if8.in_sub = s; if8.in_a = a; if8.in_b = b; if8.in_carry = c;
      end
    endcase
  endtask

  task automatic set_ready(input int w, input bit r);
    case (w)
      0:       if4.out_ready = r;
      1:       if1.out_ready = r;
      default: if8.out_ready = r;
    endcase
  endtask

  // Counts clock edges from the accept edge until out_valid is seen.
  task automatic wait_result(input int w);
    got_lat = 0;
    do begin
      @(posedge clk);
      got_lat++;
      @(negedge clk);
    end while (!get_valid(w) && got_lat < 40);
    sample(w);
  endtask

  task automatic applyStimulus(input int w, input bit s, input logic [31:0] a,
                               input logic [31:0] b, input bit c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!get_ready(w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    drive(w, 1'b1, s, a, b, c);
    @(posedge clk);
    #1 drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_result(w);
  endtask

  task automatic checkOutput(input string name, input int w, input logic [31:0] er,
                             input bit ec, input bit ez, input bit ei);
    check({name, "_latency"}, 64'(got_lat), 64'(digits_of(w)));
    check({name, "_result"}, 64'(got_res), 64'(er));
    check({name, "_carry"}, 64'(got_c), 64'(ec));
    check({name, "_zero"}, 64'(got_z), 64'(ez));
    check({name, "_invalid"}, 64'(got_inv), 64'(ei));
    set_ready(w, 1'b1);
    @(posedge clk);
    #1 set_ready(w, 1'b0);
  endtask

  function automatic longint bcd2int(input logic [31:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint v, input int d);
    logic [31:0] r = '0;
    longint      t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: subtraction is A + (10^d - 1 - B) + cin, carry means the sum reached 10^d.
  task automatic model(input int d, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input bit cin, output logic [31:0] r, output bit c, output bit z);
    longint m = 1;
    longint sum;
    for (int i = 0; i < d; i++) m = m * 10;
    if (s) sum = bcd2int(a, d) + (m - 1 - bcd2int(b, d)) + longint'(cin);
    else   sum = bcd2int(a, d) + bcd2int(b, d) + longint'(cin);
    c = (sum >= m);
    r = int2bcd(sum % m, d);
    z = ((sum % m) == 0);
  endtask

  function automatic logic [31:0] rand_bcd(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [31:0] er, ra, rb;
    bit          ec, ez, rs, rc;
    bit          stable, leaked;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int w = 0; w < 3; w++) begin
      drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_ready(w, 1'b0);
    end

    vecs[0] = '{0, 16'h1234, 16'h5678, 0, 16'h6912, 0, 0, 0};
    vecs[1] = '{0, 16'h9999, 16'h0001, 0, 16'h0000, 1, 1, 0};
    vecs[2] = '{0, 16'h0009, 16'h0009, 1, 16'h0019, 0, 0, 0};
    vecs[3] = '{1, 16'h0100, 16'h0001, 1, 16'h0099, 1, 0, 0};
    vecs[4] = '{1, 16'h0001, 16'h0002, 1, 16'h9999, 0, 0, 0};
    vecs[5] = '{0, 16'h00A0, 16'h0000, 0, 16'h0100, 0, 0, 1};
    vecs[6] = '{1, 16'h0000, 16'h0000, 1, 16'h0000, 1, 1, 0};
    vecs[7] = '{1, 16'h0000, 16'h000B, 1, 16'h0005, 1, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(if4.in_ready), 1);
    check("rst_out_valid", 64'(if4.out_valid), 0);
    check("rst_out_result", 64'(if4.out_result), 0);
    check("rst_flags", 64'({if4.out_carry, if4.out_zero, if4.out_invalid}), 0);
    check("rst_out_valid_d1_d8", 64'({if1.out_valid, if8.out_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors, DIGITS=4");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].sub, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin);
      checkOutput($sformatf("vec%0d", i), 0, 32'(vecs[i].res), vecs[i].carry, vecs[i].zero, vecs[i].inv);
    end

    $display("[TB] backpressure with a held request");
    applyStimulus(0, 1'b0, 32'h4321, 32'h1111, 1'b0);
    check("bp_first_result", 64'(got_res), 64'h5432);
    drive(0, 1'b1, 1'b0, 32'h1111, 32'h2222, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0 || if4.out_result !== 16'h5432 ||
          if4.out_carry !== 1'b0 || if4.out_zero !== 1'b0)
        stable = 1'b0;
    end
    check("bp_outputs_stable", 64'(stable), 1);
    set_ready(0, 1'b1);
    @(posedge clk);
    #1 set_ready(0, 1'b0);
    check("bp_in_ready_after_handshake", 64'(if4.in_ready), 1);
    check("bp_out_valid_dropped", 64'(if4.out_valid), 0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("bp_held_req_accepted", 64'(if4.in_ready), 0);
    wait_result(0);
    checkOutput("bp_second", 0, 32'h3333, 1'b0, 1'b0, 1'b0);

    $display("[TB] random operations against decimal model");
    for (int i = 0; i < 30; i++) begin
      ra = rand_bcd(4); rb = rand_bcd(4);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      model(4, rs, ra, rb, rc, er, ec, ez);
      applyStimulus(0, rs, ra, rb, rc);
      checkOutput($sformatf("rnd4_%0d", i), 0, er, ec, ez, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      ra = rand_bcd(8); rb = rand_bcd(8);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      model(8, rs, ra, rb, rc, er, ec, ez);
      applyStimulus(2, rs, ra, rb, rc);
      checkOutput($sformatf("rnd8_%0d", i), 2, er, ec, ez, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      ra = rand_bcd(1); rb = rand_bcd(1);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      model(1, rs, ra, rb, rc, er, ec, ez);
      applyStimulus(1, rs, ra, rb, rc);
      checkOutput($sformatf("rnd1_%0d", i), 1, er, ec, ez, 1'b0);
    end

    $display("[TB] parameter sweep corners");
    applyStimulus(1, 1'b0, 32'h9, 32'h1, 1'b0);
    checkOutput("d1_9p1", 1, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 32'h99999999, 32'h00000001, 1'b0);
    checkOutput("d8_carry_chain", 2, 32'h0, 1'b1, 1'b1, 1'b0);

    $display("[TB] reset during RUN");
    applyStimulus(0, 1'b0, 32'h1234, 32'h5678, 1'b0);
    checkOutput("pre_reset", 0, 32'h6912, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0555, 32'h0444, 1'b1);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_result", 64'(if4.out_result), 0);
    check("midrun_rst_valid", 64'(if4.out_valid), 0);
    check("midrun_rst_in_ready", 64'(if4.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if4.out_valid !== 1'b0) leaked = 1'b1;
    end
    check("midrun_no_result", 64'(leaked), 0);
    applyStimulus(0, 1'b1, 32'h5000, 32'h0001, 1'b1);
    checkOutput("post_reset", 0, 32'h4999, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_dadd_serial.md
# alu_dadd_serial

Digit-serial, parametrised BCD add/subtract unit for the XM23 ALU. It is the multi-digit successor to the single-cycle 16-bit DADD datapath. It processes one BCD digit per clock, supports DIGITS-wide operands, performs add or ten's-complement subtract, and reports carry, zero and invalid-digit flags. The execute stage issues operations over a valid/ready handshake, and results return over a second valid/ready handshake.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1); operand width W = 4*DIGITS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_sub  in  1  0 = add, 1 = subtract.
- in_a  in  W  BCD operand A.
- in_b  in  W  BCD operand B.
- in_carry  in  1  carry-in (subtract: 1 = no borrow-in).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  BCD result.
- out_carry  out  1  carry out of most-significant digit (subtract: 1 = no borrow).
- out_zero  out  1  all result digits are 0.
- out_invalid  out  1  some input digit of A or B (as presented) was >9.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high, the unit captures operands and moves to RUN.
  - Captures A.
  - Captures B′ = B (add) or the per-digit nines-complement 9−B[i] (sub).
  - Sets carry register = in_carry.
  - Clears the digit counter, the invalid flag and the zero accumulator.
- RUN: each cycle, digit i = counter (LSD first) goes through the sub-module.
  - Computes s = a_i + b′_i + c in 5 bits.
  - If s > 9: digit = (s+6)[3:0], c = 1. Otherwise digit = s[3:0], c = 0. The 5-bit sum guarantees no 4-bit overflow loss.
  - The digit shifts into the result register from the MSD end.
  - invalid |= (a_i>9)|(b_i>9), checked on the original B.
  - zero &= (digit==0).
  - The counter increments. When counter == DIGITS−1, the FSM moves to DONE.
- DONE: out_valid=1 and outputs are stable. When out_ready is high, the FSM returns to IDLE.
- in_ready=0 in RUN and DONE. A request presented then is neither captured nor lost; the producer holds it.
- Subtract with in_carry=1 yields A−B mod 10^DIGITS. out_carry=0 signals a borrow, i.e. a ten's-complement negative result.
- Invalid digits still run through the arithmetic rule above. The result is defined but not meaningful; out_invalid=1 flags it.

## Timing
- Reset (async assert) sets:
  - state=IDLE, in_ready=1 (after reset).
  - out_valid=0, out_result=0, out_carry=0, out_zero=0, out_invalid=0.
  - Internal registers = 0.
- Reset deassertion is synchronous to clk by the system reset synchroniser. The unit accepts the first request at the first clk edge with rst_n high.
- An accept at edge k puts the FSM in RUN after k. Digit i is processed at edge k+1+i. out_valid rises after edge k+DIGITS. Latency is DIGITS cycles.
- Throughput: one operation per DIGITS+2 cycles minimum (accept edge, DIGITS RUN edges, handshake edge).
- out_result/flags change only on the final RUN edge. They hold while out_valid=1 and out_ready=0.
- out_valid & out_ready at edge m: IDLE after m. in_ready=1 from m, and a new accept is possible at edge m+1.
- Reset asserted mid-RUN or in DONE: the operation is discarded, all outputs clear immediately, and no result is produced.
- DIGITS=1: RUN lasts one cycle.

## Structure
- Package xm23_bcd_pkg contains:
  - typedef bcd_digit_t (logic [3:0]).
  - enum dadd_state_t {IDLE, RUN, DONE}.
  - constants BCD_NINE=4'd9, BCD_ADJ=4'd6.
- Sub-module bcd_digit_add (combinational): inputs a, b (bcd_digit_t) and cin; outputs sum (bcd_digit_t) and cout. Instantiate exactly once, as the datapath of the serial loop.
- Top level holds the FSM, the ⌈log2 DIGITS⌉ counter and the A/B′/result shift registers.

## Test plan
- Add, DIGITS=4: A=0x1234, B=0x5678, cin=0 → out_result=0x6912, carry=0, zero=0, invalid=0. out_valid rises exactly 4 cycles after the accept edge.
- Carry chain: A=0x9999, B=0x0001, cin=0 → result=0x0000, carry=1, zero=1. Per-digit 5-bit sum case: A=0x0009, B=0x0009, cin=1 → 0x0019.
- Subtract: A=0x0100, B=0x0001, sub=1, cin=1 → 0x0099, carry=1. A=0x0001, B=0x0002 → 0x9999, carry=0 (borrow).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable, in_ready=0, and a request held on in_valid is accepted the cycle after out_ready=1 handshake.
- Invalid digit: A=0x00A0, B=0x0000 → out_invalid=1, result per rule. Then reset asserted during RUN of a valid op → outputs 0 immediately, in_ready=1 after reset.
- Parameter sweep: DIGITS=1 (9+1, cin=0 → 0, carry=1) and DIGITS=8 (0x99999999+0x00000001 → 0x00000000, carry=1). Check latency equals DIGITS in both.
